// File: rtl/lc3_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_wb_pkg
// Purpose  : Shared definitions for the LC-3 writeback stage: write-source
//            encoding, condition-code bit positions and reset value, plus the
//            condition-code helper used by the psr logic.
// Revision : 1.0  initial release
// ============================================================================
package lc3_wb_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_COUNT = 8;
  localparam int ADDR_W    = 3;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_NPC = 2'd3
  } wb_src_e;

  localparam int PSR_N = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_P = 0;

  localparam logic [2:0] PSR_RESET = 3'b000;

  // Condition codes for a written value; exactly one bit is ever set.
  function automatic logic [2:0] psr_of(input logic [DATA_W-1:0] value);
    logic [2:0] cc;
    cc = '0;
    if (value[DATA_W-1])   cc[PSR_N] = 1'b1;
    else if (value == '0)  cc[PSR_Z] = 1'b1;
    else                   cc[PSR_P] = 1'b1;
    return cc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_regfile.sv
`default_nettype none
// ============================================================================
// Module   : lc3_regfile
// Purpose  : 8 x 16 register file, one synchronous write port, two
//            combinational read ports, asynchronous active-low clear.
// Ports    : clock      - rising-edge clock
//            reset      - async active-low clear of all registers
//            i_we       - write enable
//            i_waddr    - write address
//            i_wdata    - write data
//            i_raddr1/2 - read addresses
//            o_rdata1/2 - read data (current contents, no write bypass)
// Revision : 1.0  initial release
// ============================================================================
module lc3_regfile
  import lc3_wb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_mem [REG_COUNT];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads see the stored contents only: a same-cycle write to the read
  // address becomes visible after the edge.
  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule
`default_nettype wire

// File: rtl/lc3_writeback.sv
`default_nettype none
// ============================================================================
// Module   : lc3_writeback
// Purpose  : LC-3 writeback stage: selects the write-back source, writes the
//            register file and maintains the {N,Z,P} condition codes.
// Ports    : clock            - rising-edge clock
//            reset            - async active-low reset
//            enable_writeback - commit write and psr update at next edge
//            W_control_in     - source select (ALU, MEM, PC, NPC)
//            aluout/memout/pcout/npc - candidate write values
//            sr1/sr2          - read addresses
//            dr               - destination register
//            VSR1/VSR2        - combinational read data
//            psr              - registered condition codes {N,Z,P}
// Revision : 1.0  initial release
// ============================================================================
module lc3_writeback
  import lc3_wb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_writeback,
  input  logic [1:0]  W_control_in,
  input  logic [15:0] aluout,
  input  logic [15:0] memout,
  input  logic [15:0] pcout,
  input  logic [15:0] npc,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  input  logic [2:0]  dr,
  output logic [15:0] VSR1,
  output logic [15:0] VSR2,
  output logic [2:0]  psr
);

  logic [15:0] w_wdata;
  logic [2:0]  r_psr;

  // Only the selected bus reaches w_wdata, so unknowns on the others
  // cannot leak into the written value.
  always_comb begin
    w_wdata = aluout;
    case (wb_src_e'(W_control_in))
      WB_ALU:  w_wdata = aluout;
      WB_MEM:  w_wdata = memout;
      WB_PC:   w_wdata = pcout;
      WB_NPC:  w_wdata = npc;
      default: w_wdata = aluout;
    endcase
  end

  lc3_regfile u_regfile (
    .clock    (clock),
    .reset    (reset),
    .i_we     (enable_writeback),
    .i_waddr  (dr),
    .i_wdata  (w_wdata),
    .i_raddr1 (sr1),
    .i_raddr2 (sr2),
    .o_rdata1 (VSR1),
    .o_rdata2 (VSR2)
  );

  // Condition codes follow the value being written, not the old R[dr].
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_psr <= PSR_RESET;
    end else if (enable_writeback) begin
      r_psr <= psr_of(w_wdata);
    end
  end

  assign psr = r_psr;

endmodule
`default_nettype wire

// File: tb/tb_lc3_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_writeback
// Purpose  : Self-checking bench for lc3_writeback: directed scenarios plus
//            randomized traffic against a behavioural register-file model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lc3_writeback;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_writeback = 1'b0;
  logic [1:0]  W_control_in = 2'd0;
  logic [15:0] aluout = 16'h0;
  logic [15:0] memout = 16'h0;
  logic [15:0] pcout  = 16'h0;
  logic [15:0] npc    = 16'h0;
  logic [2:0]  sr1 = 3'd0;
  logic [2:0]  sr2 = 3'd0;
  logic [2:0]  dr  = 3'd0;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic [2:0]  psr;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_r [8];
  logic [2:0]  m_psr;

  lc3_writeback dut (
    .clock            (clock),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .W_control_in     (W_control_in),
    .aluout           (aluout),
    .memout           (memout),
    .pcout            (pcout),
    .npc              (npc),
    .sr1              (sr1),
    .sr2              (sr2),
    .dr               (dr),
    .VSR1             (VSR1),
    .VSR2             (VSR2),
    .psr              (psr)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_cc(input logic [15:0] v);
    if (v[15])          return 3'b100;
    else if (v == 16'h0) return 3'b010;
    else                return 3'b001;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
    m_psr = 3'b000;
  endtask

  // Advance one rising edge, applying the architectural write rule to the model.
  task automatic do_edge();
    logic [15:0] v;
    @(posedge clock);
    if (reset && enable_writeback) begin
      case (W_control_in)
        2'd0: v = aluout;
        2'd1: v = memout;
        2'd2: v = pcout;
        default: v = npc;
      endcase
      m_r[dr] = v;
      m_psr   = exp_cc(v);
    end
    #1;
  endtask

  task automatic set_write(input logic en, input logic [1:0] ctrl, input logic [15:0] val,
                           input logic [2:0] d);
    enable_writeback = en;
    W_control_in     = ctrl;
    aluout = 16'h0; memout = 16'h0; pcout = 16'h0; npc = 16'h0;
    case (ctrl)
      2'd0: aluout = val;
      2'd1: memout = val;
      2'd2: pcout  = val;
      default: npc = val;
    endcase
    dr = d;
  endtask

  logic [15:0] r3_exp [4];
  logic [2:0]  r3_cc  [4];

  initial begin
    model_reset();
    r3_exp[0] = 16'h1234; r3_exp[1] = 16'h8000; r3_exp[2] = 16'h0000; r3_exp[3] = 16'h3001;
    r3_cc[0]  = 3'b001;   r3_cc[1]  = 3'b100;   r3_cc[2]  = 3'b010;   r3_cc[3]  = 3'b001;

    // Reset held: reads are zero, psr cleared, even with a write request pending.
    enable_writeback = 1'b1; aluout = 16'h5555; dr = 3'd4;
    #2;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      #1;
      check_val("rst_vsr1", VSR1, 16'h0);
      check_val("rst_vsr2", VSR2, 16'h0);
    end
    check_val("rst_psr", {13'h0, psr}, 16'h0);
    enable_writeback = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      #1;
      check_val("post_rst_vsr1", VSR1, 16'h0);
      check_val("post_rst_vsr2", VSR2, 16'h0);
    end
    check_val("post_rst_psr", {13'h0, psr}, 16'h0);
    do_edge();

    // Four writes to R3, one per source.
    sr1 = 3'd3; sr2 = 3'd3;
    for (int k = 0; k < 4; k++) begin
      enable_writeback = 1'b1;
      W_control_in = 2'(k);
      aluout = 16'h1234; memout = 16'h8000; pcout = 16'h0000; npc = 16'h3001;
      dr = 3'd3;
      do_edge();
      check_val("r3_src", VSR1, r3_exp[k]);
      check_val("r3_psr", {13'h0, psr}, {13'h0, r3_cc[k]});
    end

    // Same-cycle read of the destination sees the old value.
    set_write(1'b1, 2'd0, 16'hBEEF, 3'd5);
    sr1 = 3'd5;
    #1;
    check_val("r5_before", VSR1, 16'h0000);
    do_edge();
    check_val("r5_after", VSR1, 16'hBEEF);
    check_val("r5_psr", {13'h0, psr}, 16'h4);

    // Disabled writes hold everything.
    set_write(1'b0, 2'd0, 16'hFFFF, 3'd2);
    sr1 = 3'd2;
    for (int k = 0; k < 10; k++) begin
      do_edge();
      check_val("hold_r2", VSR1, 16'h0000);
      check_val("hold_psr", {13'h0, psr}, 16'h4);
    end

    // Async reset mid-cycle after a write to R1.
    set_write(1'b1, 2'd0, 16'h00AA, 3'd1);
    sr1 = 3'd1;
    do_edge();
    check_val("r1_written", VSR1, 16'h00AA);
    enable_writeback = 1'b0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_val("midrst_vsr1", VSR1, 16'h0000);
    check_val("midrst_psr", {13'h0, psr}, 16'h0);

    // Write held across an edge during reset is aborted, then lands after release.
    set_write(1'b1, 2'd0, 16'h1111, 3'd6);
    sr1 = 3'd6;
    do_edge();
    check_val("abort_r6", VSR1, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_val("abort_r6_rel", VSR1, 16'h0000);
    do_edge();
    check_val("first_wr_r6", VSR1, 16'h1111);
    check_val("first_wr_psr", {13'h0, psr}, 16'h1);

    // R0 is an ordinary register.
    set_write(1'b1, 2'd1, 16'h7FFF, 3'd0);
    do_edge();
    enable_writeback = 1'b0;
    sr1 = 3'd0; sr2 = 3'd0;
    #1;
    check_val("r0_vsr1", VSR1, 16'h7FFF);
    check_val("r0_vsr2", VSR2, 16'h7FFF);
    check_val("r0_psr", {13'h0, psr}, 16'h1);

    // Randomized traffic against the model, with unknowns on unused buses.
    for (int it = 0; it < 400; it++) begin
      enable_writeback = ($urandom_range(0, 3) != 0);
      W_control_in = 2'($urandom_range(0, 3));
      aluout = 16'($urandom); memout = 16'($urandom);
      pcout  = 16'($urandom); npc    = 16'($urandom);
      if ($urandom_range(0, 7) == 0) aluout = 16'h0;
      if ($urandom_range(0, 3) == 0) begin
        if (W_control_in != 2'd0) aluout = 'x;
        if (W_control_in != 2'd1) memout = 'x;
        if (W_control_in != 2'd2) pcout  = 'x;
        if (W_control_in != 2'd3) npc    = 'x;
      end
      sr1 = 3'($urandom_range(0, 7));
      sr2 = 3'($urandom_range(0, 7));
      dr  = 3'($urandom_range(0, 7));
      #1;
      check_val("rnd_pre_vsr1", VSR1, m_r[sr1]);
      check_val("rnd_pre_vsr2", VSR2, m_r[sr2]);
      check_val("rnd_pre_psr", {13'h0, psr}, {13'h0, m_psr});
      if ($urandom_range(0, 39) == 0) begin
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check_val("rnd_rst_vsr1", VSR1, 16'h0);
        check_val("rnd_rst_psr", {13'h0, psr}, 16'h0);
        reset = 1'b1;
      end
      do_edge();
      check_val("rnd_vsr1", VSR1, m_r[sr1]);
      check_val("rnd_vsr2", VSR2, m_r[sr2]);
      check_val("rnd_psr", {13'h0, psr}, {13'h0, m_psr});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
